// File: rtl/adder_bist_checker.sv
// Exhaustive BIST engine for an N-bit ripple adder: drives every {A,B,Cin}, checks the
// delayed response against a golden sum. Optional MISR signature under ADDER_BIST_MISR_EN.
module adder_bist_checker #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic                 Cin,
    input  logic [WIDTH-1:0]     SUM,
    input  logic                 Cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic [15:0]          signature
);

    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam int unsigned RW = WIDTH + 1;
    localparam logic [2:0]  DRAIN_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [VW-1:0] vec, vec_nxt;
    logic [2:0]    drain_cnt, drain_cnt_nxt;
    logic          busy_nxt, done_nxt, pass_nxt;
    logic [15:0]   err_nxt;
    logic [VW-1:0] ffv_nxt;

    logic          accept_c;
    logic          run_c;
    logic [VW-1:0] dly_vec;
    logic          dly_valid;
    logic [RW-1:0] golden_c;
    logic [RW-1:0] resp_c;
    logic          mismatch_c;

    assign A   = vec[VW-1 -: WIDTH];
    assign B   = vec[WIDTH:1];
    assign Cin = vec[0];

    assign run_c    = (state == S_RUN);
    assign accept_c = start && ((state == S_IDLE) || (state == S_DONE));

    // Expected path: the driven vector delayed to line up with the DUT response
    if (LATENCY == 0) begin : g_nodelay
        assign dly_vec   = vec;
        assign dly_valid = run_c;
    end else begin : g_delay
        logic [LATENCY-1:0][VW:0] pipe;

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe[0] <= '0;
            end else begin
                pipe[0] <= {vec, run_c};
            end
        end

        for (genvar g = 1; g < LATENCY; g++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe[g] <= '0;
                end else begin
                    pipe[g] <= pipe[g-1];
                end
            end
        end

        assign dly_vec   = pipe[LATENCY-1][VW:1];
        assign dly_valid = pipe[LATENCY-1][0];
    end

    assign golden_c   = RW'(dly_vec[VW-1 -: WIDTH]) + RW'(dly_vec[WIDTH:1]) + RW'(dly_vec[0]);
    assign resp_c     = {Cout, SUM};
    assign mismatch_c = dly_valid && (resp_c != golden_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec            <= '0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            state          <= state_nxt;
            vec            <= vec_nxt;
            drain_cnt      <= drain_cnt_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            first_fail_vec <= ffv_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        drain_cnt_nxt = drain_cnt;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        err_nxt       = err_count;
        ffv_nxt       = first_fail_vec;

        // Error bookkeeping; only possible while responses are still arriving
        if (mismatch_c) begin
            if (err_count != 16'hFFFF) begin
                err_nxt = err_count + 16'd1;
            end
            if (err_count == 16'd0) begin
                ffv_nxt = dly_vec;
            end
        end

        case (state)
            S_RUN: begin
                if (vec == '1) begin
                    vec_nxt = '0;
                    if (LATENCY == 0) begin
                        state_nxt = S_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == 16'd0);
                    end else begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = DRAIN_LAST;
                    end
                end else begin
                    vec_nxt = vec + VW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == 16'd0);
                end else begin
                    drain_cnt_nxt = drain_cnt - 3'd1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new run
                if (accept_c) begin
                    state_nxt     = S_RUN;
                    vec_nxt       = '0;
                    drain_cnt_nxt = '0;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    err_nxt       = '0;
                    ffv_nxt       = '0;
                end
            end
        endcase
    end

`ifdef ADDER_BIST_MISR_EN
    logic [15:0] sig_q, sig_nxt;

    assign signature = sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 16'hFFFF;
        end else begin
            sig_q <= sig_nxt;
        end
    end

    // MISR x^16+x^12+x^5+1: shift once per compared response, fold the response in
    always_comb begin
        sig_nxt = sig_q;
        if (accept_c) begin
            sig_nxt = 16'hFFFF;
        end else if (dly_valid) begin
            sig_nxt = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(resp_c);
        end
    end
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: three WIDTH=2 engines (LATENCY 0/1/3) against modelled adders
// with selectable faults; optional MISR checks when ADDER_BIST_MISR_EN is defined.
module tb_adder_bist_checker;

    localparam int NI       = 3;
    localparam int NVEC     = 32;
    localparam int LAT [NI] = '{0, 1, 3};
`ifdef ADDER_BIST_MISR_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  a_w    [NI];
    logic [1:0]  b_w    [NI];
    logic        cin_w  [NI];
    logic [1:0]  sum_w  [NI];
    logic        cout_w [NI];
    logic        busy_w [NI];
    logic        done_w [NI];
    logic        pass_w [NI];
    logic [15:0] err_w  [NI];
    logic [4:0]  ffv_w  [NI];
    logic [15:0] sig_w  [NI];

    int          mode;
    logic [4:0]  tgt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    adder_bist_checker #(.WIDTH(2), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .start(start), .A(a_w[0]), .B(b_w[0]), .Cin(cin_w[0]),
        .SUM(sum_w[0]), .Cout(cout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_fail_vec(ffv_w[0]), .signature(sig_w[0]));
    adder_bist_checker #(.WIDTH(2), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .A(a_w[1]), .B(b_w[1]), .Cin(cin_w[1]),
        .SUM(sum_w[1]), .Cout(cout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_fail_vec(ffv_w[1]), .signature(sig_w[1]));
    adder_bist_checker #(.WIDTH(2), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .start(start), .A(a_w[2]), .B(b_w[2]), .Cin(cin_w[2]),
        .SUM(sum_w[2]), .Cout(cout_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .first_fail_vec(ffv_w[2]), .signature(sig_w[2]));

    // Adder under test: ideal sum with an optional injected fault
    function automatic logic [2:0] adder_resp(input logic [4:0] v, input int m, input logic [4:0] t);
        logic [2:0] r;
        r = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
        case (m)
            1: r[2] = 1'b0;
            2: r[0] = 1'b1;
            3: if (v == t) r[1] = ~r[1];
            default: ;
        endcase
        return r;
    endfunction

    logic [2:0] p1;
    logic [2:0] p3 [3];

    assign {cout_w[0], sum_w[0]} = adder_resp({a_w[0], b_w[0], cin_w[0]}, mode, tgt);

    always @(posedge clk) begin
        p1    <= adder_resp({a_w[1], b_w[1], cin_w[1]}, mode, tgt);
        p3[0] <= adder_resp({a_w[2], b_w[2], cin_w[2]}, mode, tgt);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign {cout_w[1], sum_w[1]} = p1;
    assign {cout_w[2], sum_w[2]} = p3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_outs_L%0d", tag, LAT[i]),
                  32'({a_w[i], b_w[i], cin_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], ffv_w[i]}), 32'd0);
            check($sformatf("%s_sig_L%0d", tag, LAT[i]), 32'(sig_w[i]), 32'(SIG_RST));
        end
    endtask

    // One complete run; expectations from an exhaustive sweep of the adder model
    task automatic do_run(input int m, input logic [4:0] t, input bit mid_start);
        int         exp_err;
        logic [4:0] exp_ffv;
        int         bad [NI];
        mode    = m;
        tgt     = t;
        exp_err = 0;
        exp_ffv = 5'd0;
        for (int k = 0; k < NVEC; k++) begin
            logic [4:0] v;
            int         s;
            v = 5'(k);
            s = int'(v[4:3]) + int'(v[2:1]) + int'(v[0]);
            if (int'(adder_resp(v, m, t)) != s) begin
                if (exp_err == 0) exp_ffv = v;
                exp_err++;
            end
        end
        for (int i = 0; i < NI; i++) bad[i] = 0;

        pulse_start();
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (mid_start && cyc == 10) start = 1'b1;
            if (cyc == 11) start = 1'b0;
            for (int i = 0; i < NI; i++) begin
                logic [4:0] exp_drv;
                logic       exp_busy;
                exp_drv  = (cyc < NVEC) ? 5'(cyc) : 5'd0;
                exp_busy = (cyc < NVEC + LAT[i]);
                if ({a_w[i], b_w[i], cin_w[i]} !== exp_drv || busy_w[i] !== exp_busy ||
                    done_w[i] !== !exp_busy || pass_w[i] !== (!exp_busy && exp_err == 0))
                    bad[i]++;
            end
        end

        for (int i = 0; i < NI; i++) begin
            check($sformatf("seq_m%0d_L%0d", m, LAT[i]), 32'(bad[i]), 32'd0);
            check($sformatf("err_m%0d_L%0d", m, LAT[i]), 32'(err_w[i]), 32'(exp_err));
            check($sformatf("ffv_m%0d_L%0d", m, LAT[i]), 32'(ffv_w[i]), 32'(exp_ffv));
            check($sformatf("pass_m%0d_L%0d", m, LAT[i]), 32'(pass_w[i]), 32'(exp_err == 0));
`ifndef ADDER_BIST_MISR_EN
            check($sformatf("sig_m%0d_L%0d", m, LAT[i]), 32'(sig_w[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tgt   = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        do_run(0, 5'd0, 1'b0);
        do_run(1, 5'd0, 1'b0);
        do_run(2, 5'd0, 1'b1);
        for (int r = 0; r < 5; r++)
            do_run(int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        // Abort mid-run at vector 10, then a clean run must follow
        mode = 1;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_vec", 32'({a_w[1], b_w[1], cin_w[1]}), 32'd10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midrst");
        do_run(0, 5'd0, 1'b0);

`ifdef ADDER_BIST_MISR_EN
        begin
            logic [15:0] s1, s2, s3;
            do_run(0, 5'd0, 1'b0);
            s1 = sig_w[1];
            do_run(0, 5'd0, 1'b0);
            s2 = sig_w[1];
            do_run(1, 5'd0, 1'b0);
            s3 = sig_w[1];
            check("sig_nonzero", 32'(s1 != 16'd0), 32'd1);
            check("sig_repeat", 32'(s2), 32'(s1));
            check("sig_fault_differs", 32'(s3 != s1), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
